// File: rtl/seq_alu_if.sv
// Start/Busy/Done handshake bundle between the control unit and seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       AluCtrl;
  logic [WIDTH-1:0] DataIn1;
  logic [WIDTH-1:0] DataIn2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] AluResult;
  logic             Zero;
  logic             Overflow;

  modport master (
    output Start, AluCtrl, DataIn1, DataIn2,
    input  Busy, Done, AluResult, Zero, Overflow
  );
  modport slave (
    input  Start, AluCtrl, DataIn1, DataIn2,
    output Busy, Done, AluResult, Zero, Overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with registered result/flags and a Start/Busy/Done handshake.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for op 101.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      Clk,
  input logic      Rst_n,
  seq_alu_if.slave bus
);
  localparam logic [2:0]       OP_ADD = 3'b000;
  localparam logic [2:0]       OP_SUB = 3'b001;
  localparam logic [2:0]       OP_OR  = 3'b010;
  localparam logic [2:0]       OP_AND = 3'b011;
  localparam logic [2:0]       OP_SLT = 3'b100;
  localparam logic [2:0]       OP_MUL = 3'b101;
  localparam logic [2:0]       OP_SLL = 3'b110;
  localparam logic [2:0]       OP_SRL = 3'b111;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_s;
  logic             overflow_s;
  logic             slt_s;

  logic [WIDTH-1:0] aluResult_r;
  logic             zero_r;
  logic             overflow_r;
  logic             done_r;

  // Single-cycle datapath evaluated on the live operands.
  always_comb begin
    sum_s      = bus.DataIn1 + bus.DataIn2;
    diff_s     = bus.DataIn1 - bus.DataIn2;
    slt_s      = ($signed(bus.DataIn1) < $signed(bus.DataIn2));
    result_s   = ZERO_W;
    overflow_s = 1'b0;
    case (bus.AluCtrl)
      OP_ADD: begin
        result_s   = sum_s;
        overflow_s = (bus.DataIn1[WIDTH-1] == bus.DataIn2[WIDTH-1]) &&
                     (sum_s[WIDTH-1] != bus.DataIn1[WIDTH-1]);
      end
      OP_SUB: begin
        result_s   = diff_s;
        overflow_s = (bus.DataIn1[WIDTH-1] != bus.DataIn2[WIDTH-1]) &&
                     (diff_s[WIDTH-1] != bus.DataIn1[WIDTH-1]);
      end
      OP_OR:  result_s = bus.DataIn1 | bus.DataIn2;
      OP_AND: result_s = bus.DataIn1 & bus.DataIn2;
      OP_SLT: result_s = {{(WIDTH-1){1'b0}}, slt_s};
      // Without the multiplier, op 101 is flagged illegal through Overflow.
      OP_MUL: begin
        result_s   = ZERO_W;
        overflow_s = 1'b1;
      end
      OP_SLL: result_s = bus.DataIn1 << bus.DataIn2[SHW-1:0];
      OP_SRL: result_s = bus.DataIn1 >> bus.DataIn2[SHW-1:0];
      default: begin
        result_s   = ZERO_W;
        overflow_s = 1'b0;
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] multiplicand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] accNext_s;
  logic [WIDTH-1:0]   multiplier_r;
  logic [CW-1:0]      count_r;

  // Accumulator value after conditionally adding the multiplicand this cycle.
  always_comb begin
    if (multiplier_r[0]) begin
      accNext_s = acc_r + multiplicand_r;
    end else begin
      accNext_s = acc_r;
    end
  end

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r        <= ST_IDLE;
      busy_r         <= 1'b0;
      multiplicand_r <= {(2*WIDTH){1'b0}};
      acc_r          <= {(2*WIDTH){1'b0}};
      multiplier_r   <= ZERO_W;
      count_r        <= {CW{1'b0}};
      aluResult_r    <= ZERO_W;
      zero_r         <= 1'b0;
      overflow_r     <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.Start && (bus.AluCtrl == OP_MUL)) begin
            multiplicand_r <= {ZERO_W, bus.DataIn1};
            multiplier_r   <= bus.DataIn2;
            acc_r          <= {(2*WIDTH){1'b0}};
            count_r        <= CW'(WIDTH);
            state_r        <= ST_MUL;
            busy_r         <= 1'b1;
          end else if (bus.Start) begin
            aluResult_r <= result_s;
            zero_r      <= (result_s == ZERO_W);
            overflow_r  <= overflow_s;
            done_r      <= 1'b1;
          end
        end
        ST_MUL: begin
          acc_r          <= accNext_s;
          multiplicand_r <= multiplicand_r << 1'b1;
          multiplier_r   <= multiplier_r >> 1'b1;
          count_r        <= count_r - ONE_C;
          // Last iteration: the product is complete in accNext_s this cycle.
          if (count_r == ONE_C) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            aluResult_r <= accNext_s[WIDTH-1:0];
            zero_r      <= (accNext_s[WIDTH-1:0] == ZERO_W);
            overflow_r  <= |accNext_s[2*WIDTH-1:WIDTH];
            done_r      <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_r;
`else
  // Registered outputs; every operation completes in one cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      aluResult_r <= ZERO_W;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= bus.Start;
      if (bus.Start) begin
        aluResult_r <= result_s;
        zero_r      <= (result_s == ZERO_W);
        overflow_r  <= overflow_s;
      end
    end
  end

  assign bus.Busy = 1'b0;
`endif

  assign bus.Done      = done_r;
  assign bus.AluResult = aluResult_r;
  assign bus.Zero      = zero_r;
  assign bus.Overflow  = overflow_r;
endmodule
